// File: rtl/cla_add_pipe_if.sv
// Operand/result channel bundle for cla_add_pipe: one valid/ready input beat
// channel and one valid/ready result channel. clk/rst are plain ports on the block.
interface cla_add_pipe_if #(
    parameter int WIDTH = 28
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             zero;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, zero
    );

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, zero
    );
endinterface

// File: rtl/cla_add_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor (4-bit groups, two-level group lookahead).
// Optional macro CLA_ADD_ZERO_FLAG_EN adds a registered sum==0 flag; otherwise zero is tied low.
module cla_add_pipe #(
    parameter int WIDTH = 28
) (
    input  logic           clk,
    input  logic           rst,
    cla_add_pipe_if.slave  bus
);
    // Valid/ready: a beat moves across a channel on a rising edge where valid && ready;
    // valid and payload are held stable by the sender until that edge, and neither
    // in_ready nor out_valid depends on in_valid.

    localparam int NG  = WIDTH / 4;
    localparam int NG4 = ((NG + 3) / 4) * 4;
    localparam int NS  = NG4 / 4;
    localparam int NS4 = ((NS + 3) / 4) * 4;

    if (WIDTH % 4 != 0) begin : g_width_check
        $error("cla_add_pipe: WIDTH must be a multiple of 4");
    end

    // Expanded 4-bit lookahead: carries c[0..4] from generate/propagate and carry-in.
    function automatic logic [4:0] la4(input logic [3:0] g, input logic [3:0] p, input logic ci);
        logic [4:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (&p & ci);
        return c;
    endfunction

    logic             s1_en;
    logic             s2_en;

    logic [WIDTH-1:0] bop;
    logic [WIDTH-1:0] g_d,  g_q;
    logic [WIDTH-1:0] p_d,  p_q;
    logic [NG-1:0]    gg_d, gg_q;
    logic [NG-1:0]    gp_d, gp_q;
    logic             c0_d, c0_q;
    logic             s1_valid_q;

    logic [NG4-1:0]   gg_pad;
    logic [NG4-1:0]   gp_pad;
    logic [NS4-1:0]   sg;
    logic [NS4-1:0]   sp;
    logic [NS4:0]     sc;
    logic [NG4:0]     gc;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;
    logic             out_valid_q;

    assign s2_en        = !out_valid_q || bus.out_ready;
    assign s1_en        = !s1_valid_q || s2_en;
    assign bus.in_ready = s1_en;

    always_comb begin : stage1_comb
        logic [4:0] cy;
        cy   = '0;
        bop  = bus.sub ? ~bus.b : bus.b;
        c0_d = bus.sub | bus.cin;
        g_d  = bus.a & bop;
        p_d  = bus.a ^ bop;
        gg_d = '0;
        gp_d = '0;
        for (int k = 0; k < NG; k++) begin
            cy      = la4(g_d[4*k +: 4], p_d[4*k +: 4], 1'b0);
            gg_d[k] = cy[4];
            gp_d[k] = &p_d[4*k +: 4];
        end
    end

    // Padding groups use g=0/p=1 so they pass a carry through unchanged.
    always_comb begin : stage2_comb
        logic [4:0] cy;
        cy             = '0;
        gg_pad         = '0;
        gp_pad         = '1;
        gg_pad[NG-1:0] = gg_q;
        gp_pad[NG-1:0] = gp_q;

        sg = '0;
        sp = '1;
        for (int s = 0; s < NS; s++) begin
            cy    = la4(gg_pad[4*s +: 4], gp_pad[4*s +: 4], 1'b0);
            sg[s] = cy[4];
            sp[s] = &gp_pad[4*s +: 4];
        end

        sc    = '0;
        sc[0] = c0_q;
        for (int t = 0; t < NS4 / 4; t++) begin
            cy              = la4(sg[4*t +: 4], sp[4*t +: 4], sc[4*t]);
            sc[4*t+1 +: 4]  = cy[4:1];
        end

        gc = '0;
        for (int s = 0; s < NS; s++) begin
            cy              = la4(gg_pad[4*s +: 4], gp_pad[4*s +: 4], sc[s]);
            gc[4*s]         = sc[s];
            gc[4*s+1 +: 4]  = cy[4:1];
        end

        c = '0;
        for (int k = 0; k < NG; k++) begin
            cy           = la4(g_q[4*k +: 4], p_q[4*k +: 4], gc[k]);
            c[4*k +: 4]  = cy[3:0];
        end

        sum_d  = p_q ^ c;
        cout_d = gc[NG];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            g_q         <= '0;
            p_q         <= '0;
            gg_q        <= '0;
            gp_q        <= '0;
            c0_q        <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    g_q  <= g_d;
                    p_q  <= p_d;
                    gg_q <= gg_d;
                    gp_q <= gp_d;
                    c0_q <= c0_d;
                end
            end
            if (s2_en) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    sum_q  <= sum_d;
                    cout_q <= cout_d;
                end
            end
        end
    end

`ifdef CLA_ADD_ZERO_FLAG_EN
    logic zero_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else if (s2_en && s1_valid_q) begin
            zero_q <= ~|sum_d;
        end
    end

    assign bus.zero = zero_q;
`else
    assign bus.zero = 1'b0;
`endif

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_cla_add_pipe.sv
// Bench for cla_add_pipe: directed vectors, backpressure and reset-flush scenarios,
// then random back-to-back traffic, all results scored against an arithmetic model.
module tb_cla_add_pipe;
    localparam int WIDTH = 28;
    localparam int W     = WIDTH + 1;
    localparam logic [WIDTH-1:0] MAXV = '1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   rand_ready = 1'b0;

    int checks = 0;
    int passes = 0;
    logic [W-1:0] exp_q[$];

    cla_add_pipe_if #(.WIDTH(WIDTH)) bus ();

    cla_add_pipe #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {cout, sum} from plain integer arithmetic.
    function automatic logic [W-1:0] ref_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic cin, input logic sub);
        longint unsigned ua, ub, r;
        logic [WIDTH-1:0] s;
        logic co;
        ua = longint'(a);
        ub = longint'(b);
        if (!sub) begin
            r  = ua + ub + longint'(cin);
            s  = r[WIDTH-1:0];
            co = r[WIDTH];
        end else begin
            r  = ua - ub;
            s  = r[WIDTH-1:0];
            co = (ua >= ub);
        end
        return {co, s};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard producer: record every accepted beat.
    always @(negedge clk) begin
        if (rst) exp_q.delete();
        else if (bus.in_valid && bus.in_ready)
            exp_q.push_back(ref_model(bus.a, bus.b, bus.cin, bus.sub));
    end

    // Monitor: compare every delivered result against the oldest expectation.
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic exp_zero;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_out: got sum %h cout %0b with no beat pending", bus.sum, bus.cout);
            end else begin
                e = exp_q.pop_front();
`ifdef CLA_ADD_ZERO_FLAG_EN
                exp_zero = (e[WIDTH-1:0] == '0);
`else
                exp_zero = 1'b0;
`endif
                check("sum",  bus.sum,  e[WIDTH-1:0]);
                check("cout", bus.cout, e[WIDTH]);
                check("zero", bus.zero, exp_zero);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.cin = cin;
        bus.sub = sub;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 1000) begin
                checks++;
                $display("FAIL send_timeout: got in_ready 0 for %0d cycles, expected 1", n);
                break;
            end
            step();
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return MAXV;
            2:       return MAXV - WIDTH'($urandom_range(0, 15));
            default: return WIDTH'($urandom());
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_sum",       bus.sum,       0);
        check("rst_cout",      bus.cout,      0);
        check("rst_zero",      bus.zero,      0);
        check("rst_in_ready",  bus.in_ready,  1);
        step();

        // Carry chain and latency: result visible two edges after presentation.
        send(28'h0FFFFFF, 28'h0000001, 1'b0, 1'b0);
        @(negedge clk);
        check("lat_not_yet", bus.out_valid, 0);
        step();
        @(negedge clk);
        check("lat_out_valid", bus.out_valid, 1);
        check("chain_sum",     bus.sum,       28'h1000000);
        check("chain_cout",    bus.cout,      0);
        step();

        send(28'hFFFFFFF, 28'h0000001, 1'b0, 1'b0);
        send(28'd7, 28'd5, 1'b1, 1'b1);
        send(28'd5, 28'd7, 1'b0, 1'b1);
        send(28'd5, 28'd7, 1'b1, 1'b1);
        idle(4);

        // Backpressure: two beats fill the pipe, the third must wait.
        bus.out_ready = 1'b0;
        send(28'd1, 28'd1, 1'b0, 1'b0);
        send(28'd2, 28'd2, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        bus.a = 28'd3;
        bus.b = 28'd3;
        @(negedge clk);
        check("full_in_ready", bus.in_ready, 0);
        step();
        @(negedge clk);
        check("full_hold", bus.in_ready, 0);
        step();
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("drain_in_ready", bus.in_ready,  1);
        check("drain_beat0",    bus.out_valid, 1);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("drain_beat1", bus.out_valid, 1);
        step();
        @(negedge clk);
        check("drain_beat2", bus.out_valid, 1);
        idle(3);

        // Reset with two beats in flight: both must vanish.
        bus.out_ready = 1'b0;
        send(28'd10, 28'd20, 1'b0, 1'b0);
        send(28'd30, 28'd40, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_sum",       bus.sum,       0);
        check("mid_rst_in_ready",  bus.in_ready,  1);
        idle(5);

        // Random traffic with random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rand_ready = 1'b0;
        step();
        bus.out_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            step();
            n++;
        end
        check("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
